l2_tcdm_bank_ctrl: RTL and testbench
====================================

# l2_tcdm_bank_ctrl

Per-bank controller between one interleaved L2 slave port of the SoC interconnect and a single-port SRAM macro. Translates the TCDM request/grant/response protocol into SRAM chip-select and write-enable timing, and returns read data with fixed latency. Zero-initialises the bank after reset. Optionally stores and checks per-byte parity. One instance is placed per `l2_interleaved_slaves[i]` port.

## Interface
Parameters:
- `NR_L2_PORTS`, default 4: number of interleaved banks; sets the address bit offset.
- `BANK_ADDR_WIDTH`, default 13: word-index width of the bank (depth is 2^BANK_ADDR_WIDTH).
- `DATA_WIDTH`, default 32: TCDM data width. Fixed at 32.
- `OUT_REG`, default 1: 1 registers the read data (2-cycle latency); 0 passes SRAM data through (1-cycle latency).
- `INIT_ON_RESET`, default 1: 1 zero-sweeps the bank after reset.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `req_i` in 1: TCDM request.
- `add_i` in 32: byte address.
- `wen_i` in 1: 1 = read, 0 = write.
- `wdata_i` in 32: write data.
- `be_i` in 4: byte enables.
- `gnt_o` out 1: grant.
- `r_valid_o` out 1: response valid.
- `r_rdata_o` out 32: read data.
- `r_opc_o` out 1: 1 = error response.
- `mem_req_o` out 1: SRAM chip select, active-high.
- `mem_we_o` out 1: SRAM write.
- `mem_addr_o` out BANK_ADDR_WIDTH: SRAM word address.
- `mem_wdata_o` out MW: SRAM write data.
- `mem_be_o` out MW/8 (parity) or 4: SRAM byte/bit-group enables.
- `mem_rdata_i` in MW: SRAM read data.
- `init_done_o` out 1: bank ready.
- `par_err_o` out 1: single-cycle parity error pulse.
- `par_err_cnt_o` out 16: saturating error count.

MW = 36 with `L2_BANK_PARITY_EN`, otherwise 32.

## Operation
- States: INIT and RUN. Reset enters INIT if `INIT_ON_RESET` is 1, otherwise RUN.
- INIT:
  - Counter `init_addr` runs 0..2^BANK_ADDR_WIDTH-1, one write per cycle: data all zero, all enables set, parity bits 0.
  - `gnt_o` = 0 and `init_done_o` = 0 throughout.
  - After the last address, move to RUN.
  - Any incoming `req_i` stays pending; it is never dropped.
- RUN:
  - `gnt_o` = `req_i`; there is no backpressure.
  - `mem_addr_o` = `add_i[2+log2(NR_L2_PORTS) +: BANK_ADDR_WIDTH]`.
  - `mem_req_o` = `req_i`; `mem_we_o` = `~wen_i`; `mem_be_o` = `be_i`.
- Every granted request, read or write, produces exactly one `r_valid_o`, in order.
- Write responses: `r_rdata_o` = 0, `r_opc_o` = 0.
- Reset during INIT or RUN:
  - The counter restarts at 0.
  - In-flight responses are discarded: the pipeline valid bits are cleared.

## Timing
- Grant is combinational in the request cycle (cycle 0). The SRAM samples at the end of cycle 0.
- OUT_REG=0: `r_valid_o` is high in cycle 1; `r_rdata_o` comes from `mem_rdata_i`.
- OUT_REG=1: `r_valid_o` is high in cycle 2; data is registered.
- Throughput is one request per cycle; back-to-back mixed reads and writes return responses in order.
- Reset values:
  - `gnt_o` = 0, `r_valid_o` = 0, `r_rdata_o` = 0, `r_opc_o` = 0.
  - `init_done_o` = 0 (1 when `INIT_ON_RESET` = 0).
  - `par_err_o` = 0, `par_err_cnt_o` = 0.
  - `mem_req_o` = 0 in the reset cycle; the first INIT write happens in the cycle after reset deasserts.
- INIT lasts exactly 2^BANK_ADDR_WIDTH cycles. `init_done_o` rises in the following cycle together with the first possible grant.

## Configuration
- Macro `L2_BANK_PARITY_EN`.
- Defined:
  - Each byte is stored with an even-parity bit; MW = 36, laid out as {byte, parity} × 4.
  - On a read response, each enabled byte is checked.
  - Any mismatch: `r_opc_o` = 1 and `par_err_o` = 1 in the response cycle, and `par_err_cnt_o` increments, saturating at 0xFFFF.
- Not defined:
  - MW = 32.
  - `par_err_o`, `par_err_cnt_o` and `r_opc_o` are tied to 0, with no parity logic.
  - Port list is unchanged apart from the widths.

## Structure
- Package `pkg_l2_bank`: state enum `l2_bank_state_e` {INIT, RUN}, and constants `L2_PAR_BITS_PER_WORD` and `L2_ERR_CNT_WIDTH` = 16.
- Sub-module `l2_bank_parity`: combinational per-byte parity generate/check.

## Test plan
- Reset with BANK_ADDR_WIDTH=4 and `req_i` held high:
  - `gnt_o` stays 0 for 16 cycles.
  - 16 zero writes at addresses 0..15 are seen on the `mem_*` ports.
  - `init_done_o` and `gnt_o` rise in cycle 17.
- Address decode: write 0xDEADBEEF, be=0xF, at add 0x1C000010 with NR_L2_PORTS=4, then read it back.
  - `mem_addr_o` = 1.
  - Read returns 0xDEADBEEF with `r_valid_o` 2 cycles after grant (OUT_REG=1), or 1 cycle after (OUT_REG=0).
- Byte write: be=0x2, wdata=0x0000AA00 over a zeroed word, then read → 0x0000AA00.
- Back-to-back traffic: W, R, R, W, R on consecutive cycles → five in-order `r_valid_o` pulses on consecutive cycles.
- Reset mid-stream with a read outstanding → no `r_valid_o` after reset, and INIT restarts at address 0.
- Parity (macro defined): inject a flipped bit on `mem_rdata_i` during a read.
  - `r_opc_o` = 1 and `par_err_o` pulses once.
  - Count goes 0→1.
  - Count holds at 0xFFFF once saturated.

Source files
------------

// File: rtl/pkg_l2_bank.sv
// pkg_l2_bank: shared types and constants for the L2 TCDM bank controller.
// The parity width follows the L2_BANK_PARITY_EN macro.
package pkg_l2_bank;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } l2_bank_state_e;

`ifdef L2_BANK_PARITY_EN
   localparam int L2_PAR_BITS_PER_WORD = 4;
`else
   localparam int L2_PAR_BITS_PER_WORD = 0;
`endif

   localparam int L2_ERR_CNT_WIDTH = 16;

endpackage

// File: rtl/l2_bank_parity.sv
// l2_bank_parity: combinational per-byte even-parity encode and check.
// Each 9-bit SRAM lane is laid out as {byte, parity}. Only built when
// L2_BANK_PARITY_EN is defined; without it the bank stores plain data.
`ifdef L2_BANK_PARITY_EN
module l2_bank_parity (
   input  logic [31:0] i_wdata,
   output logic [35:0] o_wdata_enc,
   input  logic [35:0] i_rdata_enc,
   input  logic [3:0]  i_be,
   output logic [31:0] o_rdata,
   output logic        o_err
);

   // Encode write lanes, strip parity from read lanes, flag bad enabled bytes.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      o_wdata_enc = '0;
      o_rdata     = '0;
      o_err       = 1'b0;
      for (int b = 0; b < 4; b++) begin
         o_wdata_enc[9*b +: 9] = {i_wdata[8*b +: 8], ^i_wdata[8*b +: 8]};
         o_rdata[8*b +: 8]     = i_rdata_enc[9*b+1 +: 8];
         o_err                 = o_err | (i_be[b] & (^i_rdata_enc[9*b +: 9]));
      end
   end

endmodule
`endif

// File: rtl/l2_tcdm_bank_ctrl.sv
// l2_tcdm_bank_ctrl: one interleaved L2 TCDM slave port driving a single-port
// SRAM bank. Zero-sweeps the bank after reset, grants without backpressure and
// returns in-order responses with fixed latency (OUT_REG selects 1 or 2 cycles).
// Define L2_BANK_PARITY_EN to store and check per-byte even parity.
module l2_tcdm_bank_ctrl
   import pkg_l2_bank::*;
#(
   parameter int  NR_L2_PORTS     = 4,
   parameter int  BANK_ADDR_WIDTH = 13,
   parameter int  DATA_WIDTH      = 32,
   parameter int  OUT_REG         = 1,
   parameter int  INIT_ON_RESET   = 1,
   localparam int MW              = DATA_WIDTH + L2_PAR_BITS_PER_WORD,
   localparam int BW              = DATA_WIDTH / 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_i,
   input  logic [31:0]                 add_i,
   input  logic                        wen_i,
   input  logic [DATA_WIDTH-1:0]       wdata_i,
   input  logic [BW-1:0]               be_i,
   output logic                        gnt_o,
   output logic                        r_valid_o,
   output logic [DATA_WIDTH-1:0]       r_rdata_o,
   output logic                        r_opc_o,
   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [BANK_ADDR_WIDTH-1:0]  mem_addr_o,
   output logic [MW-1:0]               mem_wdata_o,
   output logic [BW-1:0]               mem_be_o,
   input  logic [MW-1:0]               mem_rdata_i,
   output logic                        init_done_o,
   output logic                        par_err_o,
   output logic [L2_ERR_CNT_WIDTH-1:0] par_err_cnt_o
);

   // Word index sits above the byte offset and the bank-select bits.
   localparam int ADDR_LSB = 2 + $clog2(NR_L2_PORTS);

   l2_bank_state_e             r_state;
   logic [BANK_ADDR_WIDTH-1:0] r_init_addr;
   logic                       r_init_done;

   logic                       r_v1;
   logic                       r_rd1;
   logic [BW-1:0]              r_be1;

   logic [MW-1:0]              w_wdata_enc;
   logic [DATA_WIDTH-1:0]      w_rdata_dec;
   logic                       w_chk_err;
   logic [DATA_WIDTH-1:0]      w_rsp_data;
   logic                       w_rsp_err;
   logic                       w_err_resp;
   logic                       w_unused_ok;

   // Bank state: sweep zeros over every word after reset, then serve requests.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      if (rst_i) begin
         r_state     <= (INIT_ON_RESET != 0) ? INIT : RUN;
         r_init_addr <= '0;
         r_init_done <= (INIT_ON_RESET == 0);
      end else if (r_state == INIT) begin
         r_init_addr <= r_init_addr + 1'b1;
         if (&r_init_addr) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
         end
      end
   end

   assign init_done_o = r_init_done;
   // Requests arriving during the sweep are simply not granted; the master holds them.
   assign gnt_o       = req_i & (r_state == RUN) & ~rst_i;

`ifdef L2_BANK_PARITY_EN
   l2_bank_parity u_parity (
      .i_wdata     (wdata_i),
      .o_wdata_enc (w_wdata_enc),
      .i_rdata_enc (mem_rdata_i),
      .i_be        (r_be1),
      .o_rdata     (w_rdata_dec),
      .o_err       (w_chk_err)
   );
`else
   assign w_wdata_enc = wdata_i;
   assign w_rdata_dec = mem_rdata_i;
   assign w_chk_err   = 1'b0;
`endif

   // SRAM port: zero-write sweep during INIT, direct request mapping in RUN.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (!rst_i) begin
         if (r_state == INIT) begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = r_init_addr;
            mem_be_o   = '1;
         end else begin
            mem_req_o   = req_i;
            mem_we_o    = ~wen_i;
            mem_addr_o  = add_i[ADDR_LSB +: BANK_ADDR_WIDTH];
            mem_wdata_o = w_wdata_enc;
            mem_be_o    = be_i;
         end
      end
   end

   // Request stage: track granted requests while the SRAM access completes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_v1  <= 1'b0;
         r_rd1 <= 1'b0;
         r_be1 <= '0;
      end else begin
         r_v1  <= gnt_o;
         r_rd1 <= gnt_o & wen_i;
         r_be1 <= be_i;
      end
   end

   // Writes answer with zero data; reads return the SRAM word.
   assign w_rsp_data = (r_v1 & r_rd1) ? w_rdata_dec : '0;
   assign w_rsp_err  = r_v1 & r_rd1 & w_chk_err;

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                  r_v2;
         logic                  r_err2;
         logic [DATA_WIDTH-1:0] r_rdata2;

         // Response stage: register the response to cut the SRAM-to-port path.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_v2     <= 1'b0;
               r_err2   <= 1'b0;
               r_rdata2 <= '0;
            end else begin
               r_v2     <= r_v1;
               r_err2   <= w_rsp_err;
               r_rdata2 <= w_rsp_data;
            end
         end

         assign r_valid_o  = r_v2;
         assign r_rdata_o  = r_rdata2;
         assign w_err_resp = r_err2;
      end else begin : g_out_comb
         assign r_valid_o  = r_v1;
         assign r_rdata_o  = w_rsp_data;
         assign w_err_resp = w_rsp_err;
      end
   endgenerate

`ifdef L2_BANK_PARITY_EN
   logic [L2_ERR_CNT_WIDTH-1:0] r_err_cnt;

   // Error counter: count failed read responses, sticking at all ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err_cnt <= '0;
      end else if (w_err_resp && !(&r_err_cnt)) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign r_opc_o       = w_err_resp;
   assign par_err_o     = w_err_resp;
   assign par_err_cnt_o = r_err_cnt;
   // Address bits outside the word index select the bank upstream.
   assign w_unused_ok   = ^add_i;
`else
   assign r_opc_o       = 1'b0;
   assign par_err_o     = 1'b0;
   assign par_err_cnt_o = '0;
   assign w_unused_ok   = ^{add_i, w_err_resp, r_be1};
`endif

endmodule

// File: tb/tb_l2_tcdm_bank_ctrl.sv
// tb_l2_tcdm_bank_ctrl: self-checking bench for l2_tcdm_bank_ctrl with a
// behavioural SRAM and a word-level reference model of the bank.
// Parity checks are compiled in when L2_BANK_PARITY_EN is defined.
module tb_l2_tcdm_bank_ctrl;
   import pkg_l2_bank::*;

   localparam int P_NR      = 4;
   localparam int P_BAW     = 4;
   localparam int P_OUT_REG = 1;
   localparam int DEPTH     = 1 << P_BAW;
   localparam int LAT       = (P_OUT_REG != 0) ? 2 : 1;
   localparam int MW        = 32 + L2_PAR_BITS_PER_WORD;
   localparam int G         = MW / 4;

   logic               clk_i   = 1'b0;
   logic               rst_i   = 1'b1;
   logic               req_i   = 1'b0;
   logic [31:0]        add_i   = '0;
   logic               wen_i   = 1'b1;
   logic [31:0]        wdata_i = '0;
   logic [3:0]         be_i    = '0;
   logic               gnt_o;
   logic               r_valid_o;
   logic [31:0]        r_rdata_o;
   logic               r_opc_o;
   logic               mem_req_o;
   logic               mem_we_o;
   logic [P_BAW-1:0]   mem_addr_o;
   logic [MW-1:0]      mem_wdata_o;
   logic [3:0]         mem_be_o;
   logic [MW-1:0]      mem_rdata_i;
   logic               init_done_o;
   logic               par_err_o;
   logic [15:0]        par_err_cnt_o;

   l2_tcdm_bank_ctrl #(
      .NR_L2_PORTS     (P_NR),
      .BANK_ADDR_WIDTH (P_BAW),
      .DATA_WIDTH      (32),
      .OUT_REG         (P_OUT_REG),
      .INIT_ON_RESET   (1)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (req_i),
      .add_i         (add_i),
      .wen_i         (wen_i),
      .wdata_i       (wdata_i),
      .be_i          (be_i),
      .gnt_o         (gnt_o),
      .r_valid_o     (r_valid_o),
      .r_rdata_o     (r_rdata_o),
      .r_opc_o       (r_opc_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_be_o      (mem_be_o),
      .mem_rdata_i   (mem_rdata_i),
      .init_done_o   (init_done_o),
      .par_err_o     (par_err_o),
      .par_err_cnt_o (par_err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural single-port SRAM with byte-lane enables and registered read.
   logic [MW-1:0] sram [DEPTH];
   logic [MW-1:0] sram_q = '0;
   logic [MW-1:0] sram_tmp;
   logic          g_flip_on = 1'b0;

   // Corrupts the parity bit of byte 0 on the read path while enabled.
   assign mem_rdata_i = sram_q ^ MW'(g_flip_on);

   always @(posedge clk_i) begin
      if (mem_req_o) begin
         if (mem_we_o) begin
            sram_tmp = sram[mem_addr_o];
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) sram_tmp[b*G +: G] = mem_wdata_o[b*G +: G];
            sram[mem_addr_o] <= sram_tmp;
         end else begin
            sram_q <= sram[mem_addr_o];
         end
      end
   end

   // Reference model: word array, response queue, error counter.
   typedef struct {
      int          due;
      logic [31:0] data;
      logic        opc;
      logic        tchk;
      logic [31:0] texp;
   } rsp_t;

   rsp_t        q[$];
   logic [31:0] m_mem [DEPTH];
   int          m_init_left = 0;
   int          m_cnt       = 0;
   bit          m_prev_rst  = 1'b1;
   int          cyc         = 0;
   int          n_tests     = 0;
   int          n_fail      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive after the edge, check at the falling edge, update the model.
   task automatic cycle(input logic rst, input logic req, input logic wen,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic tchk, input logic [31:0] texp);
      rsp_t e;
      logic exp_v;
      int   idx;
      @(posedge clk_i);
      #1;
      rst_i   = rst;
      req_i   = req;
      wen_i   = wen;
      add_i   = addr;
      wdata_i = wdata;
      be_i    = be;
      @(negedge clk_i);
      if (rst) begin
         check("rst_gnt", gnt_o, 0);
         check("rst_mem_req", mem_req_o, 0);
         if (m_prev_rst) begin
            check("rst_r_valid", r_valid_o, 0);
            check("rst_r_rdata", r_rdata_o, 0);
            check("rst_r_opc", r_opc_o, 0);
            check("rst_init_done", init_done_o, 0);
            check("rst_par_err", par_err_o, 0);
            check("rst_err_cnt", par_err_cnt_o, 0);
         end
         m_init_left = DEPTH;
         m_cnt       = 0;
         q.delete();
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end else begin
         if (m_init_left > 0) begin
            check("init_gnt", gnt_o, 0);
            check("init_done_low", init_done_o, 0);
            check("init_mem_req", mem_req_o, 1);
            check("init_mem_we", mem_we_o, 1);
            check("init_mem_addr", mem_addr_o, DEPTH - m_init_left);
            check("init_mem_wdata", mem_wdata_o, 0);
            check("init_mem_be", mem_be_o, 4'hF);
            m_init_left--;
         end else begin
            check("init_done", init_done_o, 1);
            check("gnt", gnt_o, req);
            check("mem_req", mem_req_o, req);
            if (req) begin
               idx = int'((addr / (4 * P_NR)) % DEPTH);
               check("mem_we", mem_we_o, !wen);
               check("mem_addr", mem_addr_o, idx);
               check("mem_be", mem_be_o, be);
               e.due  = cyc + LAT;
               e.tchk = tchk;
               e.texp = texp;
               if (wen) begin
                  e.data = m_mem[idx];
                  e.opc  = g_flip_on && be[0];
               end else begin
                  e.data = '0;
                  e.opc  = 1'b0;
                  for (int b = 0; b < 4; b++)
                     if (be[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
               end
               q.push_back(e);
            end
         end
         exp_v = (q.size() > 0) && (q[0].due == cyc);
         check("r_valid", r_valid_o, exp_v);
         check("err_cnt", par_err_cnt_o, m_cnt);
         if (exp_v) begin
            e = q.pop_front();
            check("r_rdata", r_rdata_o, e.data);
            check("r_opc", r_opc_o, e.opc);
            check("par_err", par_err_o, e.opc);
            if (e.tchk) check("tbl_rdata", r_rdata_o, e.texp);
            if (e.opc && m_cnt < 65535) m_cnt++;
         end else begin
            check("par_err_idle", par_err_o, 0);
         end
      end
      m_prev_rst = rst;
      cyc++;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
   endtask

   task automatic rand_cycle(input logic rst);
      cycle(rst, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0, 32'h0);
   endtask

   typedef struct {
      logic        req;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Directed vectors: address decode, byte write, back-to-back W R R W R.
      tbl[0]  = '{1'b1, 1'b0, 32'h1C00_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
      tbl[1]  = '{1'b1, 1'b1, 32'h1C00_0010, 32'h0,         4'hF, 32'hDEAD_BEEF};
      tbl[2]  = '{1'b1, 1'b0, 32'h1C00_0020, 32'h5555_AA55, 4'h2, 32'h0000_0000};
      tbl[3]  = '{1'b1, 1'b1, 32'h1C00_0020, 32'h0,         4'hF, 32'h0000_AA00};
      tbl[4]  = '{1'b0, 1'b1, 32'h0,         32'h0,         4'h0, 32'h0000_0000};
      tbl[5]  = '{1'b1, 1'b0, 32'h1C00_0030, 32'hCAFE_F00D, 4'hF, 32'h0000_0000};
      tbl[6]  = '{1'b1, 1'b1, 32'h1C00_0030, 32'h0,         4'hF, 32'hCAFE_F00D};
      tbl[7]  = '{1'b1, 1'b1, 32'h1C00_0010, 32'h0,         4'hF, 32'hDEAD_BEEF};
      tbl[8]  = '{1'b1, 1'b0, 32'h1C00_0030, 32'h0000_00EE, 4'h1, 32'h0000_0000};
      tbl[9]  = '{1'b1, 1'b1, 32'h1C00_0030, 32'h0,         4'hF, 32'hCAFE_F0EE};
      tbl[10] = '{1'b1, 1'b0, 32'h1C00_01FC, 32'h0102_0304, 4'hF, 32'h0000_0000};
      tbl[11] = '{1'b1, 1'b1, 32'h0000_00F0, 32'h0,         4'hF, 32'h0102_0304};

      // Garbage in the SRAM so the zero sweep is observable.
      for (int i = 0; i < DEPTH; i++) sram[i] = MW'({$urandom, $urandom});

      // Reset with a read held pending through the whole sweep.
      repeat (3) cycle(1'b1, 1'b1, 1'b1, 32'h1C00_0010, 32'h0, 4'hF, 1'b0, 32'h0);
      repeat (DEPTH + 1) cycle(1'b0, 1'b1, 1'b1, 32'h1C00_0010, 32'h0, 4'hF, 1'b1, 32'h0);
      repeat (LAT + 1) idle();

      for (int i = 0; i < 12; i++)
         cycle(1'b0, tbl[i].req, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].be,
               tbl[i].req, tbl[i].exp);
      repeat (LAT + 1) idle();

      // Random traffic against the model.
      repeat (400) rand_cycle(1'b0);
      repeat (LAT + 1) idle();

      // Reset with a read outstanding: response discarded, sweep restarts at 0.
      cycle(1'b0, 1'b1, 1'b1, 32'h1C00_0030, 32'h0, 4'hF, 1'b0, 32'h0);
      repeat (2) rand_cycle(1'b1);
      repeat (DEPTH + 150) rand_cycle(1'b0);
      repeat (LAT + 1) idle();

`ifdef L2_BANK_PARITY_EN
      // Parity: corrupted parity bit of byte 0 flags only when byte 0 is enabled.
      g_flip_on = 1'b1;
      cycle(1'b0, 1'b1, 1'b1, 32'h1C00_0030, 32'h0, 4'hF, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 32'h1C00_0030, 32'h0, 4'hE, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 32'h1C00_0030, 32'h0, 4'h1, 1'b0, 32'h0);
      repeat (LAT + 2) idle();
      // Drive the counter into saturation and confirm it sticks.
      for (int i = 0; i < 65540; i++)
         cycle(1'b0, 1'b1, 1'b1, $urandom, 32'h0, 4'hF, 1'b0, 32'h0);
      repeat (LAT + 2) idle();
      check("err_cnt_sat", par_err_cnt_o, 16'hFFFF);
      g_flip_on = 1'b0;
      repeat (2) idle();
`endif

      check("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
